// File: rtl/instr_fetch_unit.sv
// ----------------------------------------------------------------------------
// instr_fetch_unit
//   Fetch stage for the R-format core. Holds the PC and reads four bytes from
//   a byte-wide, combinational-read instruction memory, one byte per cycle.
//   The bytes are assembled big-endian into a 32-bit instruction, which is
//   then offered downstream with a valid/ready handshake. A redirect loads a
//   new PC. Fetching halts once the PC leaves the memory image.
//
// Optional feature macro: IFU_PERF_CNT_EN
//   defined   : Fetch_Count counts delivered instructions and saturates.
//               Only reset clears it.
//   undefined : Fetch_Count is tied to zero and no counter is built.
//
// Ports
//   clk            in   clock, rising edge
//   rst_n          in   asynchronous active-low reset
//   Mem_Addr       out  byte address to instruction memory
//   Mem_Data       in   byte returned for Mem_Addr in the same cycle
//   Instr          out  assembled instruction, stable while Instr_Valid=1
//   Instr_Addr     out  PC of Instr
//   Instr_Valid    out  Instr/Instr_Addr valid
//   Instr_Ready    in   downstream accepts (transfer = valid & ready)
//   Redirect_En    in   load a new PC; highest priority
//   Redirect_Addr  in   new PC, bits [1:0] ignored
//   Done           out  PC beyond memory image, fetching stopped
//   Fetch_Count    out  delivered-instruction count
//
// States
//   state  | meaning
//   F0..F3 | reading byte lane k at PC+k into Instr[31-8k -: 8]
//   HOLD   | instruction valid, waiting for downstream to accept
//   HALT   | PC out of image, no memory reads, Done=1
// ----------------------------------------------------------------------------
module instr_fetch_unit #(
    parameter int unsigned            ADDR_W     = 32,
    parameter int unsigned            IMEM_BYTES = 128,
    parameter logic [ADDR_W-1:0]      RESET_PC   = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] Mem_Addr,
    input  logic [7:0]        Mem_Data,
    output logic [31:0]       Instr,
    output logic [ADDR_W-1:0] Instr_Addr,
    output logic              Instr_Valid,
    input  logic              Instr_Ready,
    input  logic              Redirect_En,
    input  logic [ADDR_W-1:0] Redirect_Addr,
    output logic              Done,
    output logic [31:0]       Fetch_Count
);

    typedef enum logic [2:0] {
        S_F0   = 3'd0,
        S_F1   = 3'd1,
        S_F2   = 3'd2,
        S_F3   = 3'd3,
        S_HOLD = 3'd4,
        S_HALT = 3'd5
    } state_e;

    // Highest PC from which a full 4-byte word still lies inside the image.
    localparam logic [ADDR_W-1:0] LAST_PC     = ADDR_W'(IMEM_BYTES - 4);
    localparam logic [ADDR_W-1:0] PC_MASK     = ~ADDR_W'(3);
    localparam logic [ADDR_W-1:0] RESET_PC_AL = RESET_PC & PC_MASK;
    localparam state_e            RESET_STATE = (RESET_PC_AL > LAST_PC) ? S_HALT : S_F0;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [31:0]       instr_q, instr_d;
    logic [ADDR_W-1:0] instr_addr_q, instr_addr_d;
    logic [1:0]        lane;
    logic              xfer;
    logic [ADDR_W-1:0] pc_plus4;
    logic [ADDR_W-1:0] redir_pc;

    assign xfer     = (state_q == S_HOLD) && Instr_Ready;
    assign pc_plus4 = pc_q + ADDR_W'(4);
    assign redir_pc = Redirect_Addr & PC_MASK;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= RESET_STATE;
            pc_q         <= RESET_PC_AL;
            instr_q      <= '0;
            instr_addr_q <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            instr_q      <= instr_d;
            instr_addr_q <= instr_addr_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        instr_d      = instr_q;
        instr_addr_d = instr_addr_q;
        lane         = 2'd0;

        case (state_q)
            S_F0: begin
                lane            = 2'd0;
                instr_d[31:24]  = Mem_Data;
                state_d         = S_F1;
            end
            S_F1: begin
                lane            = 2'd1;
                instr_d[23:16]  = Mem_Data;
                state_d         = S_F2;
            end
            S_F2: begin
                lane            = 2'd2;
                instr_d[15:8]   = Mem_Data;
                state_d         = S_F3;
            end
            S_F3: begin
                lane            = 2'd3;
                instr_d[7:0]    = Mem_Data;
                instr_addr_d    = pc_q;
                state_d         = S_HOLD;
            end
            S_HOLD: begin
                if (xfer) begin
                    pc_d    = pc_plus4;
                    state_d = (pc_plus4 > LAST_PC) ? S_HALT : S_F0;
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_F0;
            end
        endcase

        // A redirect overrides whatever the state logic chose, including the
        // PC+4 of a coincident transfer; the transfer itself still counts.
        if (Redirect_En) begin
            pc_d    = redir_pc;
            state_d = (redir_pc > LAST_PC) ? S_HALT : S_F0;
        end
    end

    assign Mem_Addr    = pc_q + ADDR_W'(lane);
    assign Instr       = instr_q;
    assign Instr_Addr  = instr_addr_q;
    assign Instr_Valid = (state_q == S_HOLD);
    assign Done        = (state_q == S_HALT);

`ifdef IFU_PERF_CNT_EN
    logic [31:0] fetch_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_cnt_q <= '0;
        end else if (xfer && (fetch_cnt_q != 32'hFFFF_FFFF)) begin
            fetch_cnt_q <= fetch_cnt_q + 32'd1;
        end
    end

    assign Fetch_Count = fetch_cnt_q;
`else
    assign Fetch_Count = 32'd0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] Mem_Addr;
    logic [7:0]  Mem_Data;
    logic [31:0] Instr;
    logic [31:0] Instr_Addr;
    logic        Instr_Valid;
    logic        Instr_Ready;
    logic        Redirect_En;
    logic [31:0] Redirect_Addr;
    logic        Done;
    logic [31:0] Fetch_Count;

    int n_checks = 0;
    int n_errors = 0;

`ifdef IFU_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic [7:0] mem [0:127];

    always #5 clk = ~clk;

    instr_fetch_unit #(
        .ADDR_W     (32),
        .IMEM_BYTES (128),
        .RESET_PC   (32'h0)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .Mem_Addr      (Mem_Addr),
        .Mem_Data      (Mem_Data),
        .Instr         (Instr),
        .Instr_Addr    (Instr_Addr),
        .Instr_Valid   (Instr_Valid),
        .Instr_Ready   (Instr_Ready),
        .Redirect_En   (Redirect_En),
        .Redirect_Addr (Redirect_Addr),
        .Done          (Done),
        .Fetch_Count   (Fetch_Count)
    );

    assign Mem_Data = (Mem_Addr < 32'd128) ? mem[Mem_Addr[6:0]] : 8'h00;

    function automatic logic [7:0] byte_at(input logic [31:0] a);
        case (a)
            32'd0:   byte_at = 8'h01;
            32'd1:   byte_at = 8'h2A;
            32'd2:   byte_at = 8'h40;
            32'd3:   byte_at = 8'h20;
            default: byte_at = 8'(a * 32'd37 + 32'd5);
        endcase
    endfunction

    function automatic logic [31:0] exp_instr(input logic [31:0] a);
        exp_instr = {byte_at(a), byte_at(a + 1), byte_at(a + 2), byte_at(a + 3)};
    endfunction

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          bad;
        int          n_xfer;
        logic [31:0] exp_a;
        logic [31:0] last_a;

        for (int i = 0; i < 128; i++) mem[i] = byte_at(32'(i));

        rst_n         = 1'b0;
        Instr_Ready   = 1'b0;
        Redirect_En   = 1'b0;
        Redirect_Addr = '0;
        cycles(2);

        // Reset values
        check_val("rst_valid",  32'(Instr_Valid), 32'd0);
        check_val("rst_done",   32'(Done),        32'd0);
        check_val("rst_instr",  Instr,            32'd0);
        check_val("rst_iaddr",  Instr_Addr,       32'd0);
        check_val("rst_maddr",  Mem_Addr,         32'd0);
        check_val("rst_fcnt",   Fetch_Count,      32'd0);

        // 1. First fetch: valid exactly 4 cycles after release
        rst_n = 1'b1;
        cycles(3);
        check_val("lat3_valid", 32'(Instr_Valid), 32'd0);
        cycles(1);
        check_val("lat4_valid", 32'(Instr_Valid), 32'd1);
        check_val("t1_instr",   Instr,            32'h012A4020);
        check_val("t1_iaddr",   Instr_Addr,       32'd0);

        // 2. Back-pressure for 10 cycles
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            cycles(1);
            if (Instr !== 32'h012A4020 || Instr_Addr !== 32'd0 ||
                Instr_Valid !== 1'b1 || Mem_Addr !== 32'd0) bad++;
        end
        check_val("hold_stable", 32'(bad), 32'd0);
        Instr_Ready = 1'b1;
        cycles(1);
        Instr_Ready = 1'b0;
        check_val("xfer_valid", 32'(Instr_Valid), 32'd0);
        check_val("xfer_pc4",   Mem_Addr,         32'd4);

        // 3. Redirect during F2
        cycles(2);
        check_val("f2_maddr", Mem_Addr, 32'd6);
        Redirect_En   = 1'b1;
        Redirect_Addr = 32'h0000_0013;
        cycles(1);
        Redirect_En   = 1'b0;
        check_val("redir_pc",    Mem_Addr,         32'h10);
        check_val("redir_valid", 32'(Instr_Valid), 32'd0);
        cycles(4);
        check_val("redir_dvalid", 32'(Instr_Valid), 32'd1);
        check_val("redir_iaddr",  Instr_Addr,       32'h10);
        check_val("redir_instr",  Instr,            exp_instr(32'h10));
        check_val("fcnt_1",       Fetch_Count,      PERF ? 32'd1 : 32'd0);

        // Redirect coincident with a transfer: transfer counts, PC redirected
        Instr_Ready   = 1'b1;
        Redirect_En   = 1'b1;
        Redirect_Addr = 32'h40;
        cycles(1);
        Instr_Ready   = 1'b0;
        Redirect_En   = 1'b0;
        check_val("coinc_pc",    Mem_Addr,         32'h40);
        check_val("coinc_valid", 32'(Instr_Valid), 32'd0);
        check_val("coinc_fcnt",  Fetch_Count,      PERF ? 32'd2 : 32'd0);

        // 4. Full image with Ready held high from reset
        rst_n = 1'b0;
        cycles(1);
        rst_n       = 1'b1;
        Instr_Ready = 1'b1;
        n_xfer = 0;
        bad    = 0;
        exp_a  = 32'd0;
        last_a = 32'hFFFF_FFFF;
        for (int c = 0; c < 300 && !Done; c++) begin
            cycles(1);
            if (Instr_Valid) begin
                if (Instr_Addr !== exp_a || Instr !== exp_instr(exp_a)) bad++;
                last_a = Instr_Addr;
                exp_a  = exp_a + 32'd4;
                n_xfer++;
            end
        end
        check_val("img_count",  32'(n_xfer),      32'd32);
        check_val("img_data",   32'(bad),         32'd0);
        check_val("img_last",   last_a,           32'h7C);
        check_val("img_done",   32'(Done),        32'd1);
        check_val("img_fcnt",   Fetch_Count,      PERF ? 32'd32 : 32'd0);
        cycles(3);
        check_val("halt_valid", 32'(Instr_Valid), 32'd0);
        check_val("halt_stay",  32'(Done),        32'd1);

        // 5. Restart from HALT
        Instr_Ready   = 1'b0;
        Redirect_En   = 1'b1;
        Redirect_Addr = 32'h0;
        cycles(1);
        Redirect_En   = 1'b0;
        check_val("resume_done", 32'(Done), 32'd0);
        check_val("resume_pc",   Mem_Addr,  32'd0);
        cycles(4);
        check_val("resume_valid", 32'(Instr_Valid), 32'd1);
        check_val("resume_iaddr", Instr_Addr,       32'd0);
        check_val("resume_instr", Instr,            32'h012A4020);
        check_val("resume_fcnt",  Fetch_Count,      PERF ? 32'd32 : 32'd0);

        // Last in-range word, then halt after its transfer
        Redirect_En   = 1'b1;
        Redirect_Addr = 32'h7F;
        cycles(1);
        Redirect_En   = 1'b0;
        check_val("edge_pc",   Mem_Addr,  32'h7C);
        check_val("edge_done", 32'(Done), 32'd0);
        cycles(4);
        check_val("edge_instr", Instr, exp_instr(32'h7C));
        Instr_Ready = 1'b1;
        cycles(1);
        Instr_Ready = 1'b0;
        check_val("edge_halt", 32'(Done), 32'd1);

        // 6. Async reset mid-F1
        Redirect_En   = 1'b1;
        Redirect_Addr = 32'h20;
        cycles(1);
        Redirect_En   = 1'b0;
        cycles(1);
        check_val("f1_maddr", Mem_Addr, 32'h21);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("arst_maddr", Mem_Addr,         32'd0);
        check_val("arst_valid", 32'(Instr_Valid), 32'd0);
        check_val("arst_instr", Instr,            32'd0);
        check_val("arst_iaddr", Instr_Addr,       32'd0);
        check_val("arst_done",  32'(Done),        32'd0);
        check_val("arst_fcnt",  Fetch_Count,      32'd0);
        cycles(1);
        rst_n = 1'b1;
        cycles(4);
        check_val("rel_valid", 32'(Instr_Valid), 32'd1);
        check_val("rel_iaddr", Instr_Addr,       32'd0);
        check_val("rel_instr", Instr,            32'h012A4020);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
